// File: rtl/kgp_run_ctrl.sv
// Host-side run controller for the KGPRISC CPU: streams a program image into
// instruction memory, holds start high for the run, then reports done or timeout.
//
// state | meaning
// IDLE  | waiting for go; flags and counters hold their last values
// LOAD  | accepting program words, one registered imem write per accepted word
// FLUSH | final registered write lands in memory; start not yet raised
// RUN   | start high, counting cycles until stop or the timeout limit
// DONE  | one-cycle completion pulse, start low
module kgp_run_ctrl #(
   parameter int IMEM_AW = 10,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               go,
   input  logic               ld_valid,
   input  logic [DATA_W-1:0]  ld_data,
   input  logic               ld_last,
   output logic               ld_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [DATA_W-1:0]  imem_wdata,
   output logic               start,
   input  logic               stop,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic               overflow,
   output logic [CNT_W-1:0]   cycles,
   output logic [IMEM_AW:0]   words
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [IMEM_AW-1:0] PTR_MAX  = '1;
   localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TIMEOUT - 1);

   state_t             state;
   logic [IMEM_AW-1:0] ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         ptr        <= '0;
         ld_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         start      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         overflow   <= 1'b0;
         cycles     <= '0;
         words      <= '0;
      end else begin
         imem_we <= 1'b0;
         done    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (go) begin
                  state    <= S_LOAD;
                  ptr      <= '0;
                  words    <= '0;
                  cycles   <= '0;
                  timeout  <= 1'b0;
                  overflow <= 1'b0;
                  ld_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_LOAD: begin
               if (ld_valid) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= ptr;
                  imem_wdata <= ld_data;
                  words      <= words + 1'b1;
                  // Pointer parks at the top address instead of wrapping.
                  if (ptr != PTR_MAX) ptr <= ptr + 1'b1;
                  if (ld_last || ptr == PTR_MAX) begin
                     overflow <= ~ld_last;
                     ld_ready <= 1'b0;
                     state    <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               start <= 1'b1;
               state <= S_RUN;
            end
            S_RUN: begin
               cycles <= cycles + 1'b1;
               // stop has priority over the timeout limit in the same cycle.
               if (stop) begin
                  start <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (cycles == TO_LAST) begin
                  start   <= 1'b0;
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               start    <= 1'b0;
               busy     <= 1'b0;
               ld_ready <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kgp_run_ctrl.sv
// Directed bench for kgp_run_ctrl: instance A covers load/run/reset, instance B
// (4-word memory, 5-cycle limit) covers overflow and timeout.
module tb_kgp_run_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        go_a, go_b;
   logic        ld_valid, ld_last, stop;
   logic [31:0] ld_data;

   logic        ld_ready_a, imem_we_a, start_a, busy_a, done_a, timeout_a, overflow_a;
   logic [3:0]  imem_addr_a;
   logic [31:0] imem_wdata_a, cycles_a;
   logic [4:0]  words_a;

   logic        ld_ready_b, imem_we_b, start_b, busy_b, done_b, timeout_b, overflow_b;
   logic [1:0]  imem_addr_b;
   logic [31:0] imem_wdata_b, cycles_b;
   logic [2:0]  words_b;

   int vectors = 0;
   int misses  = 0;

   logic [31:0] pat [4];

   kgp_run_ctrl #(.IMEM_AW(4), .DATA_W(32), .CNT_W(32), .TIMEOUT(1000)) dut_a (
      .clk(clk), .rst(rst), .go(go_a), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_last(ld_last), .ld_ready(ld_ready_a), .imem_we(imem_we_a),
      .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a), .start(start_a),
      .stop(stop), .busy(busy_a), .done(done_a), .timeout(timeout_a),
      .overflow(overflow_a), .cycles(cycles_a), .words(words_a)
   );

   kgp_run_ctrl #(.IMEM_AW(2), .DATA_W(32), .CNT_W(32), .TIMEOUT(5)) dut_b (
      .clk(clk), .rst(rst), .go(go_b), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_last(ld_last), .ld_ready(ld_ready_b), .imem_we(imem_we_b),
      .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b), .start(start_b),
      .stop(stop), .busy(busy_b), .done(done_b), .timeout(timeout_b),
      .overflow(overflow_b), .cycles(cycles_b), .words(words_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         misses++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      pat[0] = 32'h11; pat[1] = 32'h22; pat[2] = 32'h33; pat[3] = 32'h44;
      rst = 1'b1; go_a = 1'b0; go_b = 1'b0;
      ld_valid = 1'b0; ld_last = 1'b0; stop = 1'b0; ld_data = '0;
      #2;
      chk("rst_start", start_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_we", imem_we_a, 0);
      chk("rst_cycles", cycles_a, 0);
      chk("rst_words", words_a, 0);
      chk("rst_ready", ld_ready_a, 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // 4-word load with ld_valid held high, then stop on the 7th RUN cycle
      go_a = 1'b1;
      tick();
      go_a = 1'b0;
      chk("load_ready", ld_ready_a, 1);
      chk("load_busy", busy_a, 1);
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1; ld_data = pat[i]; ld_last = (i == 3);
         tick();
         chk($sformatf("wr%0d_we", i), imem_we_a, 1);
         chk($sformatf("wr%0d_addr", i), imem_addr_a, i);
         chk($sformatf("wr%0d_data", i), imem_wdata_a, pat[i]);
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("flush_ready", ld_ready_a, 0);
      chk("flush_start", start_a, 0);
      chk("flush_words", words_a, 4);
      chk("idle_b_no_write", imem_we_b, 0);
      tick();
      chk("run_start", start_a, 1);
      chk("run_we_off", imem_we_a, 0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("run%0d_start", i), start_a, 1);
         chk($sformatf("run%0d_done", i), done_a, 0);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("done_pulse", done_a, 1);
      chk("done_start", start_a, 0);
      chk("done_cycles", cycles_a, 7);
      chk("done_timeout", timeout_a, 0);
      chk("done_busy", busy_a, 1);
      tick();
      chk("post_done", done_a, 0);
      chk("post_busy", busy_a, 0);
      chk("cycles_hold", cycles_a, 7);

      // gapped load: valid 1,0,1 gives exactly two writes
      go_a = 1'b1;
      tick();
      go_a = 1'b0;
      chk("go_clears_cycles", cycles_a, 0);
      chk("go_clears_words", words_a, 0);
      ld_valid = 1'b1; ld_data = 32'hA1;
      tick();
      chk("gap_w0_we", imem_we_a, 1);
      chk("gap_w0_addr", imem_addr_a, 0);
      ld_valid = 1'b0;
      tick();
      chk("gap_hole_we", imem_we_a, 0);
      ld_valid = 1'b1; ld_data = 32'hA2; ld_last = 1'b1;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("gap_w1_we", imem_we_a, 1);
      chk("gap_w1_addr", imem_addr_a, 1);
      chk("gap_w1_data", imem_wdata_a, 32'hA2);
      chk("gap_words", words_a, 2);
      tick();
      chk("gap_no_dup", imem_we_a, 0);
      chk("gap_start", start_a, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("gap_cycles", cycles_a, 1);
      chk("gap_done", done_a, 1);
      tick();

      // overflow then timeout on the small instance
      go_b = 1'b1;
      tick();
      go_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1; ld_data = pat[i]; ld_last = 1'b0;
         tick();
         chk($sformatf("ov%0d_addr", i), imem_addr_b, i);
         chk($sformatf("ov%0d_data", i), imem_wdata_b, pat[i]);
      end
      chk("ov_flag", overflow_b, 1);
      chk("ov_words", words_b, 4);
      chk("ov_ready", ld_ready_b, 0);
      ld_data = 32'h55;
      tick();
      ld_valid = 1'b0;
      chk("ov_5th_not_written", imem_we_b, 0);
      chk("ov_run_start", start_b, 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("to%0d_start", i), start_b, 1);
         chk($sformatf("to%0d_done", i), done_b, 0);
      end
      chk("to_pending", timeout_b, 0);
      tick();
      chk("to_cycles", cycles_b, 5);
      chk("to_flag", timeout_b, 1);
      chk("to_start", start_b, 0);
      chk("to_busy", busy_b, 0);
      chk("to_no_done", done_b, 0);
      tick();
      chk("to_idle_done", done_b, 0);
      go_b = 1'b1;
      tick();
      go_b = 1'b0;
      chk("go_clears_timeout", timeout_b, 0);
      chk("go_clears_overflow", overflow_b, 0);
      chk("go_b_cycles", cycles_b, 0);

      // asynchronous reset in the middle of a run
      go_a = 1'b1;
      tick();
      go_a = 1'b0;
      ld_valid = 1'b1; ld_data = 32'h99; ld_last = 1'b1;
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst_start", start_a, 1);
      chk("pre_rst_cycles", cycles_a, 2);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_start", start_a, 0);
      chk("arst_busy", busy_a, 0);
      chk("arst_cycles", cycles_a, 0);
      chk("arst_we", imem_we_a, 0);
      rst = 1'b0;
      tick();
      chk("arst_idle", busy_a, 0);
      chk("arst_idle_start", start_a, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
